// File: rtl/branch_info_queue.sv
// branch_info_queue
//   Circular queue of in-flight conditional branches. Fetch/dispatch allocates
//   an entry per branch, execute resolves it out of order by tag, and commit
//   retires the oldest entry in order. Each retirement produces a registered
//   PHT training update. A mispredicted retirement also produces a one-cycle
//   redirect and flushes the whole queue.
//
//   Optional build macro: BIQ_STATS_EN adds the commit and mispredict counters.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   alloc_*             new branch in (pc/pred/target); alloc_ready, alloc_tag out
//   resolve_*           execute outcome for entry resolve_tag
//   head_resolved       oldest entry is valid and resolved
//   commit_valid        ROB retires the oldest branch
//   upd_w_en/pc/taken   registered predictor update pulse
//   mispredict          registered redirect pulse, with redirect_pc
//   stat_commits/stat_mispredicts   (BIQ_STATS_EN only) free-running counters
module branch_info_queue #(
  parameter int DEPTH = 8,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [31:0]      alloc_pc,
  input  logic             alloc_pred,
  input  logic [31:0]      alloc_target,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             resolve_valid,
  input  logic [TAG_W-1:0] resolve_tag,
  input  logic             resolve_taken,
  input  logic [31:0]      resolve_target,
  output logic             head_resolved,
  input  logic             commit_valid,
  output logic             upd_w_en,
  output logic [31:0]      upd_pc,
  output logic             upd_taken,
  output logic             mispredict,
  output logic [31:0]      redirect_pc
`ifdef BIQ_STATS_EN
  ,
  output logic [31:0]      stat_commits,
  output logic [31:0]      stat_mispredicts
`endif
);

  typedef struct packed {
    logic        valid;
    logic        resolved;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] ptarget;
    logic        taken;
    logic [31:0] atarget;
  } ent_t;

  ent_t             q [DEPTH];
  logic [TAG_W-1:0] head, tail;
  logic [TAG_W:0]   count;

  ent_t hd;
  logic alloc_fire, commit_fire, hd_mis, flush;

  // All handshake outputs come from registered state only, so commit and
  // resolve never reach alloc_ready or head_resolved in the same cycle.
  assign hd            = q[head];
  assign alloc_ready   = (count != (TAG_W+1)'(DEPTH));
  assign alloc_tag     = tail;
  assign head_resolved = hd.valid && hd.resolved;

  assign alloc_fire  = alloc_valid && alloc_ready;
  assign commit_fire = commit_valid && head_resolved;
  assign hd_mis      = (hd.taken != hd.pred) || (hd.taken && (hd.atarget != hd.ptarget));
  // Every other entry is younger than the head, so a bad head drops everything.
  assign flush       = commit_fire && hd_mis;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      upd_w_en    <= 1'b0;
      upd_pc      <= '0;
      upd_taken   <= 1'b0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      upd_w_en   <= commit_fire;
      mispredict <= flush;
      if (commit_fire) begin
        upd_pc    <= hd.pc;
        upd_taken <= hd.taken;
      end
      if (flush) redirect_pc <= hd.taken ? hd.atarget : hd.pc + 32'd4;

      if (flush) begin
        for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (resolve_valid && q[resolve_tag].valid) begin
          q[resolve_tag].resolved <= 1'b1;
          q[resolve_tag].taken    <= resolve_taken;
          q[resolve_tag].atarget  <= resolve_target;
        end
        // Placed after the resolve so a same-cycle re-resolve of the head
        // cannot keep a popped entry alive.
        if (commit_fire) begin
          q[head].valid <= 1'b0;
          head          <= head + TAG_W'(1);
        end
        // Alloc only fires when not full, so tail never aliases a live head.
        if (alloc_fire) begin
          q[tail] <= '{valid: 1'b1, resolved: 1'b0, pc: alloc_pc, pred: alloc_pred,
                       ptarget: alloc_target, taken: 1'b0, atarget: '0};
          tail    <= tail + TAG_W'(1);
        end
        case ({alloc_fire, commit_fire})
          2'b10:   count <= count + (TAG_W+1)'(1);
          2'b01:   count <= count - (TAG_W+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

`ifdef BIQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_commits     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (commit_fire) stat_commits     <= stat_commits + 32'd1;
      if (flush)       stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_info_queue.sv
// Testbench for branch_info_queue: directed scenarios plus a randomized run
// checked against a queue-of-records reference model.
module tb_branch_info_queue;
  localparam int DEPTH = 8;
  localparam int TAG_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             alloc_valid, alloc_ready, alloc_pred;
  logic [31:0]      alloc_pc, alloc_target;
  logic [TAG_W-1:0] alloc_tag;
  logic             resolve_valid, resolve_taken;
  logic [TAG_W-1:0] resolve_tag;
  logic [31:0]      resolve_target;
  logic             head_resolved, commit_valid;
  logic             upd_w_en, upd_taken, mispredict;
  logic [31:0]      upd_pc, redirect_pc;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  branch_info_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
    .alloc_pred(alloc_pred), .alloc_target(alloc_target), .alloc_tag(alloc_tag),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
    .resolve_taken(resolve_taken), .resolve_target(resolve_target),
    .head_resolved(head_resolved), .commit_valid(commit_valid),
    .upd_w_en(upd_w_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .mispredict(mispredict), .redirect_pc(redirect_pc)
  );

  task automatic idle();
    alloc_valid = 0; alloc_pc = 0; alloc_pred = 0; alloc_target = 0;
    resolve_valid = 0; resolve_tag = 0; resolve_taken = 0; resolve_target = 0;
    commit_valid = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic alloc1(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
    idle(); alloc_valid = 1; alloc_pc = pc; alloc_pred = pred; alloc_target = tgt; tick(); idle();
  endtask

  task automatic resolve1(input int tag, input logic tk, input logic [31:0] tgt);
    idle(); resolve_valid = 1; resolve_tag = TAG_W'(tag); resolve_taken = tk;
    resolve_target = tgt; tick(); idle();
  endtask

  task automatic test_reset();
    alloc1(32'h40, 1, 32'h80);
    do_reset();
    total += 8;
    if (alloc_ready !== 1'b1)   $display("FAIL reset_ready got %b want 1", alloc_ready);   else pass_cnt++;
    if (alloc_tag !== 3'd0)     $display("FAIL reset_tag got %0d want 0", alloc_tag);      else pass_cnt++;
    if (head_resolved !== 1'b0) $display("FAIL reset_hr got %b want 0", head_resolved);    else pass_cnt++;
    if (upd_w_en !== 1'b0)      $display("FAIL reset_upd_w_en got %b want 0", upd_w_en);   else pass_cnt++;
    if (upd_pc !== 32'd0)       $display("FAIL reset_upd_pc got %h want 0", upd_pc);       else pass_cnt++;
    if (upd_taken !== 1'b0)     $display("FAIL reset_upd_taken got %b want 0", upd_taken); else pass_cnt++;
    if (mispredict !== 1'b0)    $display("FAIL reset_mis got %b want 0", mispredict);      else pass_cnt++;
    if (redirect_pc !== 32'd0)  $display("FAIL reset_redir got %h want 0", redirect_pc);   else pass_cnt++;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      total += 2;
      if (alloc_tag !== TAG_W'(i)) $display("FAIL fill_tag got %0d want %0d", alloc_tag, i); else pass_cnt++;
      if (alloc_ready !== 1'b1) $display("FAIL fill_ready[%0d] got %b want 1", i, alloc_ready); else pass_cnt++;
      alloc1(32'h1000 + 32'(i*4), 0, 0);
    end
    total++;
    if (alloc_ready !== 1'b0) $display("FAIL full_ready got %b want 0", alloc_ready); else pass_cnt++;
    alloc1(32'hdead, 0, 0);
    total += 2;
    if (alloc_ready !== 1'b0) $display("FAIL ninth_ready got %b want 0", alloc_ready); else pass_cnt++;
    if (alloc_tag !== 3'd0)   $display("FAIL ninth_tag got %0d want 0", alloc_tag);     else pass_cnt++;
  endtask

  task automatic test_commit_ok();
    do_reset();
    alloc1(32'h100, 1, 32'h200);
    total++;
    if (head_resolved !== 1'b0) $display("FAIL ok_hr_pre got %b want 0", head_resolved); else pass_cnt++;
    resolve1(0, 1, 32'h200);
    total++;
    if (head_resolved !== 1'b1) $display("FAIL ok_hr got %b want 1", head_resolved); else pass_cnt++;
    commit_valid = 1; tick(); idle();
    total += 4;
    if (upd_w_en !== 1'b1)     $display("FAIL ok_upd_w_en got %b want 1", upd_w_en);   else pass_cnt++;
    if (upd_pc !== 32'h100)    $display("FAIL ok_upd_pc got %h want 100", upd_pc);     else pass_cnt++;
    if (upd_taken !== 1'b1)    $display("FAIL ok_upd_taken got %b want 1", upd_taken); else pass_cnt++;
    if (mispredict !== 1'b0)   $display("FAIL ok_mis got %b want 0", mispredict);      else pass_cnt++;
    tick();
    total++;
    if (upd_w_en !== 1'b0) $display("FAIL ok_pulse got %b want 0", upd_w_en); else pass_cnt++;
  endtask

  task automatic test_mispredict(input logic tk, input logic [31:0] atgt, input logic [31:0] exp_redir);
    do_reset();
    alloc1(32'h100, 1, 32'h200);
    for (int i = 1; i < 4; i++) alloc1(32'h100 + 32'(i*16), 0, 0);
    resolve1(1, 0, 0);
    resolve1(0, tk, atgt);
    commit_valid = 1; alloc_valid = 1; alloc_pc = 32'h900;
    tick(); idle();
    total += 6;
    if (mispredict !== 1'b1)      $display("FAIL mis_strobe got %b want 1", mispredict);          else pass_cnt++;
    if (redirect_pc !== exp_redir) $display("FAIL mis_redir got %h want %h", redirect_pc, exp_redir); else pass_cnt++;
    if (alloc_tag !== 3'd0)       $display("FAIL mis_tag got %0d want 0", alloc_tag);             else pass_cnt++;
    if (head_resolved !== 1'b0)   $display("FAIL mis_hr got %b want 0", head_resolved);           else pass_cnt++;
    if (upd_taken !== tk)         $display("FAIL mis_upd_taken got %b want %b", upd_taken, tk);   else pass_cnt++;
    if (upd_pc !== 32'h100)       $display("FAIL mis_upd_pc got %h want 100", upd_pc);            else pass_cnt++;
    tick();
    total++;
    if (mispredict !== 1'b0) $display("FAIL mis_pulse got %b want 0", mispredict); else pass_cnt++;
    // Former tag 1 was resolved but must be gone after the flush.
    resolve1(1, 0, 0);
    commit_valid = 1; tick(); idle();
    total++;
    if (upd_w_en !== 1'b0) $display("FAIL mis_flushed got %b want 0", upd_w_en); else pass_cnt++;
  endtask

  task automatic test_out_of_order();
    logic [31:0] exp_pc [3];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_pc[i] = 32'h500 + 32'(i*8);
      alloc1(exp_pc[i], 0, 0);
    end
    for (int r = 0; r < 3; r++) begin
      idle(); commit_valid = 1; resolve_valid = 1; resolve_tag = TAG_W'(2 - r); resolve_taken = 0;
      tick();
      total++;
      if (upd_w_en !== 1'b0) $display("FAIL ooo_early[%0d] got %b want 0", r, upd_w_en); else pass_cnt++;
    end
    idle(); commit_valid = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total += 2;
      if (upd_w_en !== 1'b1)    $display("FAIL ooo_commit[%0d] got %b want 1", k, upd_w_en); else pass_cnt++;
      if (upd_pc !== exp_pc[k]) $display("FAIL ooo_pc[%0d] got %h want %h", k, upd_pc, exp_pc[k]); else pass_cnt++;
    end
    tick();
    total++;
    if (upd_w_en !== 1'b0) $display("FAIL ooo_drain got %b want 0", upd_w_en); else pass_cnt++;
    idle();
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < DEPTH; i++) alloc1(32'h2000 + 32'(i*4), 0, 0);
    for (int i = 0; i < DEPTH; i++) resolve1(i, 0, 0);
    idle(); commit_valid = 1; alloc_valid = 1; alloc_pc = 32'h3000;
    total++;
    if (alloc_ready !== 1'b0) $display("FAIL wrap_full got %b want 0", alloc_ready); else pass_cnt++;
    tick();
    total += 2;
    if (alloc_ready !== 1'b1) $display("FAIL wrap_ready got %b want 1", alloc_ready); else pass_cnt++;
    if (alloc_tag !== 3'd0)   $display("FAIL wrap_tag got %0d want 0", alloc_tag);     else pass_cnt++;
    tick();  // alloc into tag 0 alongside a commit
    idle(); alloc_valid = 1; tick(); idle();
    total += 2;
    if (alloc_ready !== 1'b0) $display("FAIL wrap_refull got %b want 0", alloc_ready); else pass_cnt++;
    if (alloc_tag !== 3'd2)   $display("FAIL wrap_tag2 got %0d want 2", alloc_tag);    else pass_cnt++;
  endtask

  // Reference model: ordered list of live branches, oldest first.
  typedef struct {
    int          tag;
    logic [31:0] pc, ptarget, atarget;
    logic        pred, resolved, taken;
  } ment_t;

  task automatic test_random();
    ment_t       mq[$];
    ment_t       e;
    int          mtail;
    logic        x_ready, x_hr, e_w, e_tk, e_mis, mis, idx_found;
    logic [TAG_W-1:0] x_tag;
    logic [31:0] e_pc, e_redir;
    do_reset();
    mtail = 0; e_w = 0; e_tk = 0; e_mis = 0; e_pc = 0; e_redir = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      alloc_valid  = ($urandom_range(0, 9) < 6);
      alloc_pc     = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      alloc_pred   = 1'($urandom_range(0, 1));
      alloc_target = 32'h1000 + 32'($urandom_range(0, 1) * 4);
      resolve_valid  = ($urandom_range(0, 1) == 1);
      resolve_target = 32'h1000 + 32'($urandom_range(0, 1) * 4);
      resolve_taken  = 1'($urandom_range(0, 1));
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
        e = mq[$urandom_range(0, mq.size() - 1)];
        resolve_tag   = TAG_W'(e.tag);
        resolve_taken = ($urandom_range(0, 3) != 0) ? e.pred : ~e.pred;
      end else resolve_tag = TAG_W'($urandom_range(0, DEPTH - 1));
      commit_valid = ($urandom_range(0, 1) == 1);

      x_ready = (mq.size() < DEPTH);
      x_tag   = TAG_W'(mtail);
      x_hr    = (mq.size() > 0) && mq[0].resolved;
      total += 3;
      if (alloc_ready !== x_ready)   $display("FAIL rnd_ready c%0d got %b want %b", c, alloc_ready, x_ready); else pass_cnt++;
      if (alloc_tag !== x_tag)       $display("FAIL rnd_tag c%0d got %0d want %0d", c, alloc_tag, x_tag);    else pass_cnt++;
      if (head_resolved !== x_hr)    $display("FAIL rnd_hr c%0d got %b want %b", c, head_resolved, x_hr);   else pass_cnt++;

      if (rst) begin
        mq.delete(); mtail = 0; e_w = 0; e_tk = 0; e_mis = 0; e_pc = 0; e_redir = 0;
      end else begin
        mis = 0;
        e_w = commit_valid && x_hr;
        if (e_w) begin
          e = mq[0];
          e_pc = e.pc; e_tk = e.taken;
          mis = (e.taken != e.pred) || (e.taken && e.atarget != e.ptarget);
          if (mis) e_redir = e.taken ? e.atarget : e.pc + 32'd4;
        end
        e_mis = mis;
        if (mis) begin
          mq.delete(); mtail = 0;
        end else begin
          idx_found = 0;
          foreach (mq[i]) if (mq[i].tag == int'(resolve_tag) && resolve_valid && !idx_found) begin
            mq[i].resolved = 1; mq[i].taken = resolve_taken; mq[i].atarget = resolve_target;
            idx_found = 1;
          end
          if (e_w) void'(mq.pop_front());
          if (alloc_valid && x_ready) begin
            mq.push_back('{tag: mtail, pc: alloc_pc, ptarget: alloc_target, atarget: 0,
                           pred: alloc_pred, resolved: 0, taken: 0});
            mtail = (mtail + 1) % DEPTH;
          end
        end
      end
      tick();
      total += 5;
      if (upd_w_en !== e_w)       $display("FAIL rnd_w_en c%0d got %b want %b", c, upd_w_en, e_w);       else pass_cnt++;
      if (upd_pc !== e_pc)        $display("FAIL rnd_pc c%0d got %h want %h", c, upd_pc, e_pc);          else pass_cnt++;
      if (upd_taken !== e_tk)     $display("FAIL rnd_taken c%0d got %b want %b", c, upd_taken, e_tk);    else pass_cnt++;
      if (mispredict !== e_mis)   $display("FAIL rnd_mis c%0d got %b want %b", c, mispredict, e_mis);    else pass_cnt++;
      if (redirect_pc !== e_redir) $display("FAIL rnd_redir c%0d got %h want %h", c, redirect_pc, e_redir); else pass_cnt++;
    end
    rst = 0; idle();
  endtask

  initial begin
    rst = 1; idle();
    tick(); tick();
    test_reset();
    test_fill();
    test_commit_ok();
    test_mispredict(1'b0, 32'h0,   32'h104);
    test_mispredict(1'b1, 32'h300, 32'h300);
    test_out_of_order();
    test_full_wrap();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
